adc_trig_capture: RTL and testbench
===================================

Name: adc_trig_capture

Overview:
- Acquisition front end that sits directly upstream of the oscilloscope display stage.
- Generates the ADC sample clock from the system clock and captures 8-bit samples into a circular buffer.
- Detects a level/slope trigger, keeps a pre-trigger window, then freezes one trigger-aligned frame.
- The VGA renderer reads the frozen frame through a synchronous read port and releases it with a ready/ack handshake.

Parameters:
- DATA_W, 8, sample width
- DEPTH, 640, frame length in samples (one per VGA column)
- ADDR_W, 10, buffer/read address width
- PRE, 320, pre-trigger samples; trigger sample lands at frame index PRE
- AUTO_TO, 4096, samples spent in ARMED without a trigger before a forced (auto) trigger
- HYST, 4, trigger hysteresis in LSBs (used only with the optional feature)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- adc_din  in  DATA_W  ADC parallel data
- adc_clk  out  1  ADC sample clock
- run  in  1  1 = acquire continuously; 0 = stop after the current frame
- tb_sel  in  3  timebase; sample period = 2^(tb_sel+1) clk cycles
- trig_level  in  DATA_W  trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- rd_addr  in  ADDR_W  display read index, 0..DEPTH-1
- rd_data  out  DATA_W  sample at rd_addr, 1-cycle latency
- frame_ready  out  1  frame frozen and valid for reading
- frame_ack  in  1  display finished with the frame
- triggered  out  1  1 = last frame from a real trigger, 0 = auto trigger

Behaviour:
- Reset (async assert, synchronous release): state IDLE; adc_clk=0, rd_data=0, frame_ready=0, triggered=0; all counters and pointers 0. Buffer contents undefined.
- Reset asserted mid-frame aborts the frame and discards it; no partial frame is ever flagged ready.
- Divider:
  - tb_sel is latched on the IDLE->PRETRIG transition and is constant for the whole frame.
  - Counter runs 0..P-1 with P = 2^(tb_sel+1).
  - adc_clk = 1 while count < P/2, else 0.
  - sample_tick is asserted on count==0; adc_din is registered on that cycle.
  - The divider free-runs in all states.
- State machine:
  - IDLE: wr_ptr=0. Go to PRETRIG when run=1.
  - PRETRIG: write one sample per tick at wr_ptr, with wr_ptr wrapping DEPTH-1->0. After PRE writes, go to ARMED. The trigger detector is inactive here.
  - ARMED: keep writing circularly and evaluate the trigger on each new sample.
    - Rising: prev < trig_level and cur >= trig_level. Falling: prev > trig_level and cur <= trig_level.
    - prev is the previous captured sample.
    - On trigger: trig_ptr = address just written; triggered=1; go to POST.
    - If AUTO_TO samples pass with no trigger: force trigger on the current sample; triggered=0; go to POST.
  - POST: write DEPTH-PRE-1 further samples, then go to DONE.
  - DONE: writes disabled; frame_ready=1. On frame_ack=1: frame_ready=0 next cycle, go to IDLE.
- frame_ack outside DONE is ignored. An ack coincident with entry to DONE is ignored; the ack must be seen while frame_ready=1.
- run=0 stops acquisition only in IDLE. A frame in progress always completes.
- Read port:
  - Physical address = (trig_ptr - PRE + rd_addr) mod DEPTH.
  - rd_data is registered one cycle after rd_addr.
  - rd_addr >= DEPTH returns 0.
  - Reads outside DONE return buffer contents without ordering guarantees.
- Address arithmetic: ADDR_W+1 bits with explicit mod-DEPTH correction. DEPTH is not a power of two.

Optional Feature:
- Macro: TRIG_HYST_EN
- Defined (rising slope): an arm flag sets when a sample < trig_level-HYST (saturating at 0). Trigger fires when arm=1 and cur >= trig_level, then the flag clears.
- Defined (falling slope): mirror of rising, using trig_level+HYST (saturating at 255) and cur <= trig_level.
- Defined (general): the arm flag clears on entry to ARMED.
- Undefined: plain two-sample crossing as above; HYST unused.

Test Plan:
- Reset check: hold rst_n=0, then release -> adc_clk=0, frame_ready=0, rd_data=0, triggered=0; state stays IDLE while run=0.
- Timebase: tb_sel=2 -> adc_clk period 8 clk, high 4 / low 4; samples registered on the rising phase.
- Rising trigger:
  - Stimulus: tb_sel=0, adc_din ramp 0..255 repeating, level 0x80, slope 0.
  - Required: frame_ready=1, triggered=1; rd_addr 320 -> 0x80, rd_addr 319 -> 0x7F, rd_addr 639 -> 0x80+319 mod 256.
- Falling trigger: descending ramp, level 0x40, slope 1 -> rd_addr 320 -> 0x40, rd_addr 321 -> 0x3F.
- Auto trigger: constant adc_din=0x10, level 0x80 -> frame_ready after PRE+AUTO_TO+DEPTH-PRE samples; triggered=0; all reads 0x10.
- Handshake/stop: in DONE set run=0 and pulse frame_ack -> frame_ready falls the next cycle, block stays IDLE; run=1 starts a new frame; rd_addr 700 -> 0.
- (TRIG_HYST_EN): input 0x7E/0x81 alternating, level 0x80 -> no trigger, auto fires; a 0x70 dip then 0x80 -> real trigger.

Source files
------------

// File: rtl/adc_trig_capture.sv
`timescale 1ns/1ps
// adc_trig_capture: ADC sample-clock divider, circular capture buffer, level/slope trigger
// and a frozen trigger-aligned frame for the display. Optional hysteresis: TRIG_HYST_EN.
module adc_trig_capture #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int PRE     = 320,
  parameter int AUTO_TO = 4096,
  parameter int HYST    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_din,
  output logic              adc_clk,
  input  logic              run,
  input  logic [2:0]        tb_sel,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              triggered
);

  typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POST, DONE} state_t;

  localparam int N_W = $clog2(AUTO_TO + DEPTH + 1);
  localparam logic [N_W-1:0]  PRE_LAST  = N_W'(PRE - 1);
  localparam logic [N_W-1:0]  AUTO_LAST = N_W'(AUTO_TO);
  localparam logic [N_W-1:0]  POST_LAST = N_W'(DEPTH - PRE - 2);
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PRE_X     = (ADDR_W+1)'(PRE);
  localparam logic [ADDR_W:0] BACK_X    = (ADDR_W+1)'(DEPTH - PRE);

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Frame index -> buffer address: (trig_ptr - PRE + idx) mod DEPTH, non-power-of-two wrap.
  function automatic logic [ADDR_W-1:0] frame_addr(input logic [ADDR_W-1:0] tp,
                                                   input logic [ADDR_W-1:0] idx);
    logic [ADDR_W:0] base;
    logic [ADDR_W:0] sum;
    base = ({1'b0, tp} >= PRE_X) ? {1'b0, tp} - PRE_X : {1'b0, tp} + BACK_X;
    sum  = base + {1'b0, idx};
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_sub_hyst(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] d;
    d = {1'b0, v} - (DATA_W+1)'(HYST);
    return d[DATA_W] ? '0 : d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_add_hyst(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] s;
    s = {1'b0, v} + (DATA_W+1)'(HYST);
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  state_t              state;
  logic [2:0]          tb_q;
  logic [7:0]          cnt;
  logic [8:0]          per;
  logic                tick;
  logic                vld_p0;
  logic [DATA_W-1:0]   cur_p0;
  logic                hit;
  logic                wr_go;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   trig_ptr;
  logic [N_W-1:0]      n;
  logic                rd_ok;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Divider: period 2^(tb_q+1), adc_clk rises on the edge that captures a sample.
  assign per  = 9'd2 << tb_q;
  assign tick = (cnt == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      cnt     <= ({1'b0, cnt} >= per - 9'd1) ? 8'd0 : cnt + 8'd1;
      adc_clk <= ({1'b0, cnt} < (per >> 1));
      vld_p0  <= tick;
    end
  end

  // Stage p0: captured sample (and its predecessor) presented to the FSM
`ifdef TRIG_HYST_EN
  logic                arm;
  logic                arm_set;
  logic [DATA_W-1:0]   lvl_lo;
  logic [DATA_W-1:0]   lvl_hi;

  always_ff @(posedge clk) begin
    if (tick) cur_p0 <= adc_din;
  end

  assign lvl_lo  = sat_sub_hyst(trig_level);
  assign lvl_hi  = sat_add_hyst(trig_level);
  assign hit     = arm && (trig_slope ? (cur_p0 <= trig_level) : (cur_p0 >= trig_level));
  assign arm_set = trig_slope ? (cur_p0 > lvl_hi) : (cur_p0 < lvl_lo);
`else
  logic [DATA_W-1:0]   prev_p0;

  always_ff @(posedge clk) begin
    if (tick) begin
      prev_p0 <= cur_p0;
      cur_p0  <= adc_din;
    end
  end

  assign hit = trig_slope ? (prev_p0 > trig_level && cur_p0 <= trig_level)
                          : (prev_p0 < trig_level && cur_p0 >= trig_level);
`endif

  assign wr_go = vld_p0 && (state == PRETRIG || state == ARMED || state == POST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tb_q        <= '0;
      wr_ptr      <= '0;
      trig_ptr    <= '0;
      n           <= '0;
      frame_ready <= 1'b0;
      triggered   <= 1'b0;
`ifdef TRIG_HYST_EN
      arm         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          wr_ptr <= '0;
          n      <= '0;
          if (run) begin
            tb_q  <= tb_sel;
            state <= PRETRIG;
          end
        end
        PRETRIG: if (vld_p0) begin
          wr_ptr <= ptr_inc(wr_ptr);
          if (n == PRE_LAST) begin
            n     <= '0;
            state <= ARMED;
`ifdef TRIG_HYST_EN
            arm   <= 1'b0;
`endif
          end else begin
            n <= n + N_W'(1);
          end
        end
        ARMED: if (vld_p0) begin
          wr_ptr <= ptr_inc(wr_ptr);
          // After AUTO_TO quiet samples the next one is forced as the trigger.
          if (hit || n == AUTO_LAST) begin
            trig_ptr  <= wr_ptr;
            triggered <= hit;
            n         <= '0;
            state     <= POST;
          end else begin
            n <= n + N_W'(1);
          end
`ifdef TRIG_HYST_EN
          if (hit) arm <= 1'b0;
          else if (arm_set) arm <= 1'b1;
`endif
        end
        POST: if (vld_p0) begin
          wr_ptr <= ptr_inc(wr_ptr);
          if (n == POST_LAST) begin
            frame_ready <= 1'b1;
            state       <= DONE;
          end else begin
            n <= n + N_W'(1);
          end
        end
        DONE: begin
          if (frame_ack && frame_ready) begin
            frame_ready <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= cur_p0;
  end

  // Read port: one-cycle registered lookup, out-of-range indices read as zero
  assign rd_ok  = ({1'b0, rd_addr} < DEPTH_X);
  assign rd_idx = rd_ok ? frame_addr(trig_ptr, rd_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_ok ? mem[rd_idx] : '0;
  end

endmodule

// File: tb/tb_adc_trig_capture.sv
`timescale 1ns/1ps
// Directed bench for adc_trig_capture: reset, timebase, rising/falling/auto triggers,
// reset abort and the frame_ready/frame_ack handshake.
module tb_adc_trig_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adc_din = 8'd0;
  logic       adc_clk;
  logic       run = 1'b0;
  logic [2:0] tb_sel = 3'd0;
  logic [7:0] trig_level = 8'd0;
  logic       trig_slope = 1'b0;
  logic [9:0] rd_addr = 10'd0;
  logic [7:0] rd_data;
  logic       frame_ready;
  logic       frame_ack = 1'b0;
  logic       triggered;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  adc_trig_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_din     (adc_din),
    .adc_clk     (adc_clk),
    .run         (run),
    .tb_sel      (tb_sel),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .triggered   (triggered)
  );

  function automatic logic [7:0] sample_of(input int mode, input int i);
    case (mode)
      0:       return 8'(i % 256);
      1:       return 8'(255 - (i % 256));
      2:       return 8'h10;
      3:       return (i % 2 == 1) ? 8'h81 : 8'h7E;
      default: begin
        if (i < 400)       return (i % 2 == 1) ? 8'h81 : 8'h7E;
        else if (i == 400) return 8'h70;
        else               return 8'h80;
      end
    endcase
  endfunction

  task automatic do_read(input int a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = 10'(a);
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  // Starts a frame aligned to an adc_clk high phase, feeds one new sample per adc_clk
  // fall, drops run and pokes a stray ack mid-frame, and stops at frame_ready.
  task automatic start_frame(input int mode, input logic [2:0] sel, input logic [7:0] lvl,
                             input logic slope, output int falls, output bit done);
    int idx;
    int guard;
    logic prev_adc;
    tb_sel = sel;
    trig_level = lvl;
    trig_slope = slope;
    idx = 0;
    adc_din = sample_of(mode, 0);
    guard = 0;
    @(negedge clk);
    while (adc_clk !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    run = 1'b1;
    prev_adc = adc_clk;
    falls = 0;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (c == 10) run = 1'b0;
      frame_ack = (c == 20);
      if (prev_adc === 1'b1 && adc_clk === 1'b0) begin
        falls++;
        idx++;
        adc_din = sample_of(mode, idx);
      end
      prev_adc = adc_clk;
      if (frame_ready === 1'b1) done = 1'b1;
    end
    frame_ack = 1'b0;
  endtask

  task automatic release_frame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (adc_clk !== 1'b0) begin n_bad++; $display("FAIL reset_adc_clk: got %b expected 0", adc_clk); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ready: got %b expected 0", frame_ready); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL reset_triggered: got %b expected 0", triggered); end
    repeat (1500) @(negedge clk);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL idle_no_run: got %b expected 0", frame_ready); end
  endtask

  task automatic test_timebase();
    int hi, lo, guard, falls;
    bit done;
    logic prev;
    logic [7:0] d;
    tb_sel = 3'd2;
    trig_level = 8'h80;
    trig_slope = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (20) @(negedge clk);
    prev = adc_clk;
    guard = 0;
    @(negedge clk);
    while (!(prev === 1'b0 && adc_clk === 1'b1) && guard < 100) begin
      prev = adc_clk;
      @(negedge clk);
      guard++;
    end
    hi = 0;
    while (adc_clk === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    lo = 0;
    while (adc_clk === 1'b0 && lo < 100) begin lo++; @(negedge clk); end
    n_cmp++; if (hi != 4) begin n_bad++; $display("FAIL tb2_high_cycles: got %0d expected 4", hi); end
    n_cmp++; if (lo != 4) begin n_bad++; $display("FAIL tb2_low_cycles: got %0d expected 4", lo); end
    start_frame(0, 3'd2, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL tb2_frame_ready: got 0 expected 1"); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL tb2_idx320: got %h expected 80", d); end
    do_read(321, d);
    n_cmp++; if (d !== 8'h81) begin n_bad++; $display("FAIL tb2_idx321: got %h expected 81", d); end
    release_frame();
  endtask

  task automatic test_rising();
    int falls;
    bit done;
    logic [7:0] d;
    start_frame(0, 3'd0, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rise_frame_ready: got 0 expected 1"); end
    n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL rise_triggered: got %b expected 1", triggered); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL rise_idx320: got %h expected 80", d); end
    do_read(319, d);
    n_cmp++; if (d !== 8'h7F) begin n_bad++; $display("FAIL rise_idx319: got %h expected 7f", d); end
    do_read(639, d);
    n_cmp++; if (d !== 8'hBF) begin n_bad++; $display("FAIL rise_idx639: got %h expected bf", d); end
    do_read(0, d);
    n_cmp++; if (d !== 8'h40) begin n_bad++; $display("FAIL rise_idx0: got %h expected 40", d); end
    release_frame();
  endtask

  task automatic test_reset_abort();
    tb_sel = 3'd0;
    trig_level = 8'h80;
    adc_din = 8'h10;
    @(negedge clk);
    run = 1'b1;
    repeat (100) @(negedge clk);
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL abort_triggered: got %b expected 0", triggered); end
    n_cmp++; if (adc_clk !== 1'b0) begin n_bad++; $display("FAIL abort_adc_clk: got %b expected 0", adc_clk); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL abort_no_frame: got %b expected 0", frame_ready); end
  endtask

  task automatic test_falling();
    int falls;
    bit done;
    logic [7:0] d;
    start_frame(1, 3'd0, 8'h40, 1'b1, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL fall_frame_ready: got 0 expected 1"); end
    n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL fall_triggered: got %b expected 1", triggered); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h40) begin n_bad++; $display("FAIL fall_idx320: got %h expected 40", d); end
    do_read(321, d);
    n_cmp++; if (d !== 8'h3F) begin n_bad++; $display("FAIL fall_idx321: got %h expected 3f", d); end
    do_read(319, d);
    n_cmp++; if (d !== 8'h41) begin n_bad++; $display("FAIL fall_idx319: got %h expected 41", d); end
    release_frame();
  endtask

`ifdef TRIG_HYST_EN
  task automatic test_hysteresis();
    int falls;
    bit done;
    logic [7:0] d, e;
    start_frame(3, 3'd0, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL hyst_auto_ready: got 0 expected 1"); end
    n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL hyst_auto_triggered: got %b expected 0", triggered); end
    do_read(320, d);
    do_read(321, e);
    n_cmp++; if (e !== ((d == 8'h7E) ? 8'h81 : 8'h7E)) begin n_bad++; $display("FAIL hyst_auto_alt: got %h after %h", e, d); end
    release_frame();
    start_frame(4, 3'd0, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL hyst_dip_ready: got 0 expected 1"); end
    n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL hyst_dip_triggered: got %b expected 1", triggered); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h80) begin n_bad++; $display("FAIL hyst_idx320: got %h expected 80", d); end
    do_read(319, d);
    n_cmp++; if (d !== 8'h70) begin n_bad++; $display("FAIL hyst_idx319: got %h expected 70", d); end
    do_read(318, d);
    n_cmp++; if (d !== 8'h81) begin n_bad++; $display("FAIL hyst_idx318: got %h expected 81", d); end
    release_frame();
  endtask
`else
  task automatic test_crossing();
    int falls;
    bit done;
    logic [7:0] d;
    start_frame(3, 3'd0, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL cross_frame_ready: got 0 expected 1"); end
    n_cmp++; if (triggered !== 1'b1) begin n_bad++; $display("FAIL cross_triggered: got %b expected 1", triggered); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h81) begin n_bad++; $display("FAIL cross_idx320: got %h expected 81", d); end
    do_read(319, d);
    n_cmp++; if (d !== 8'h7E) begin n_bad++; $display("FAIL cross_idx319: got %h expected 7e", d); end
    do_read(318, d);
    n_cmp++; if (d !== 8'h81) begin n_bad++; $display("FAIL cross_idx318: got %h expected 81", d); end
    release_frame();
  endtask
`endif

  task automatic test_auto();
    int falls;
    bit done;
    logic [7:0] d;
    start_frame(2, 3'd0, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL auto_frame_ready: got 0 expected 1"); end
    // PRE + (AUTO_TO+1) + (DEPTH-PRE-1) frame samples plus the one in flight at start.
    n_cmp++; if (falls != 4737) begin n_bad++; $display("FAIL auto_sample_count: got %0d expected 4737", falls); end
    n_cmp++; if (triggered !== 1'b0) begin n_bad++; $display("FAIL auto_triggered: got %b expected 0", triggered); end
    do_read(0, d);
    n_cmp++; if (d !== 8'h10) begin n_bad++; $display("FAIL auto_idx0: got %h expected 10", d); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h10) begin n_bad++; $display("FAIL auto_idx320: got %h expected 10", d); end
    do_read(639, d);
    n_cmp++; if (d !== 8'h10) begin n_bad++; $display("FAIL auto_idx639: got %h expected 10", d); end
    release_frame();
  endtask

  task automatic test_handshake();
    int falls;
    bit done;
    logic [7:0] d;
    start_frame(0, 3'd0, 8'h80, 1'b0, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL hs_frame_ready: got 0 expected 1"); end
    do_read(700, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL hs_idx700: got %h expected 00", d); end
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL hs_hold_ready: got %b expected 1", frame_ready); end
    @(negedge clk);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL hs_ack_drop: got %b expected 0", frame_ready); end
    @(negedge clk);
    frame_ack = 1'b0;
    repeat (1500) @(negedge clk);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL hs_stay_idle: got %b expected 0", frame_ready); end
    start_frame(1, 3'd0, 8'h40, 1'b1, falls, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL hs_restart_ready: got 0 expected 1"); end
    do_read(320, d);
    n_cmp++; if (d !== 8'h40) begin n_bad++; $display("FAIL hs_restart_idx320: got %h expected 40", d); end
    release_frame();
  endtask

  initial begin
    test_reset();
    test_timebase();
    test_rising();
    test_reset_abort();
    test_falling();
`ifdef TRIG_HYST_EN
    test_hysteresis();
`else
    test_crossing();
`endif
    test_auto();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
